// File: rtl/intensity_pkg.sv
// Shared constants, sample type and LED thermometer helper for the intensity meter.
package intensity_pkg;

   localparam int unsigned DATA_W             = 8;
   localparam int unsigned LOG_WINDOW_DEFAULT = 3;

   typedef logic [DATA_W-1:0] sample_t;

   // Bit i lights when the level exceeds 32*i, giving a bar-graph code.
   function automatic logic [7:0] thermo8(input sample_t value);
      logic [7:0] code;
      code = '0;
      for (int i = 0; i < 8; i++) begin
         code[i] = (value > sample_t'(32 * i));
      end
      return code;
   endfunction

endpackage

// File: rtl/intensity_led_bar.sv
// Registered thermometer encoder for the level display; only built with INTENSITY_LED_BAR_EN.
`ifdef INTENSITY_LED_BAR_EN
module intensity_led_bar
   import intensity_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  sample_t    value,
   output logic [7:0] led
);

   always_ff @(posedge clk) begin
      if (reset) begin
         led <= '0;
      end else if (load) begin
         led <= thermo8(value);
      end
   end

endmodule
`endif

// File: rtl/intensity.sv
// Audio-intensity meter: averages 2^LOG_WINDOW samples and publishes the mean once per window.
// Build option INTENSITY_LED_BAR_EN adds a registered thermometer output led.
module intensity
   import intensity_pkg::*;
#(
   parameter int unsigned LOG_WINDOW = LOG_WINDOW_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] out
`ifdef INTENSITY_LED_BAR_EN
   ,
   output logic [7:0]        led
`endif
);

   localparam int unsigned ACC_W = DATA_W + LOG_WINDOW;

   logic [LOG_WINDOW-1:0] cnt;
   logic [ACC_W-1:0]      acc;
   sample_t               out_r;

   logic                  last_c;
   logic [ACC_W-1:0]      sum_c;
   sample_t               avg_c;

   // The accumulator is wide enough that the final sum cannot overflow.
   always_comb begin
      last_c = &cnt;
      sum_c  = acc + ACC_W'(data);
      avg_c  = sample_t'(sum_c >> LOG_WINDOW);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         acc   <= '0;
         out_r <= '0;
      end else if (last_c) begin
         cnt   <= '0;
         acc   <= '0;
         out_r <= avg_c;
      end else begin
         cnt   <= cnt + LOG_WINDOW'(1);
         acc   <= sum_c;
      end
   end

   assign out = out_r;

`ifdef INTENSITY_LED_BAR_EN
   intensity_led_bar u_led_bar (
      .clk   (clk),
      .reset (reset),
      .load  (last_c),
      .value (avg_c),
      .led   (led)
   );
`endif

endmodule

// File: tb/tb_intensity.sv
// Directed, table-driven bench for the intensity meter (default window of 8 samples).
module tb_intensity;
   import intensity_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data;
   logic [7:0] out;
`ifdef INTENSITY_LED_BAR_EN
   logic [7:0] led;
`endif

   intensity dut (
      .clk   (clk),
      .reset (reset),
      .data  (data),
      .out   (out)
`ifdef INTENSITY_LED_BAR_EN
      ,
      .led   (led)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [7:0] d;
      logic [7:0] exp_out;
      logic [7:0] exp_led;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic add(input logic r, input logic [7:0] d, input int n,
                      input logic [7:0] eo, input logic [7:0] el);
      vec_t v;
      v.rst = r; v.d = d; v.exp_out = eo; v.exp_led = el;
      repeat (n) vecs.push_back(v);
   endtask

   task automatic apply(input logic r, input logic [7:0] d);
      reset = r;
      data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int idx,
                        input logic [7:0] eo, input logic [7:0] el);
      checks++;
      if (out !== eo) begin
         errors++;
         $display("FAIL %s[%0d] out=%h expected %h", name, idx, out, eo);
      end
`ifdef INTENSITY_LED_BAR_EN
      checks++;
      if (led !== el) begin
         errors++;
         $display("FAIL %s[%0d] led=%h expected %h", name, idx, led, el);
      end
`endif
   endtask

   logic [7:0] win [8];

   initial begin
      reset = 1'b1;
      data  = 8'h00;

      // Reset, then a constant 0x10 window.
      add(1, 8'h00, 2, 8'h00, 8'h00);
      add(0, 8'h10, 7, 8'h00, 8'h00);
      add(0, 8'h10, 1, 8'h10, 8'h01);

      // Mixed window, sum 784 -> 98; previous average holds for 7 more edges.
      win = '{8'h71, 8'h55, 8'h0F, 8'h33, 8'h92, 8'hFF, 8'h77, 8'h00};
      for (int i = 0; i < 8; i++) begin
         add(0, win[i], 1, (i == 7) ? 8'h62 : 8'h10, (i == 7) ? 8'h0F : 8'h01);
      end

      // Full-scale window: no overflow.
      add(0, 8'hFF, 7, 8'h62, 8'h0F);
      add(0, 8'hFF, 1, 8'hFF, 8'hFF);

      // Sum 7 truncates to 0, then 0x09 window.
      add(0, 8'h01, 7, 8'hFF, 8'hFF);
      add(0, 8'h00, 1, 8'h00, 8'h00);
      add(0, 8'h09, 7, 8'h00, 8'h00);
      add(0, 8'h09, 1, 8'h09, 8'h01);

      // Mid-window reset discards the partial sum.
      add(0, 8'hFF, 4, 8'h09, 8'h01);
      add(1, 8'hFF, 1, 8'h00, 8'h00);
      add(0, 8'h08, 7, 8'h00, 8'h00);
      add(0, 8'h08, 1, 8'h08, 8'h01);

      // LED thresholds: 32 is not above 32, 33 is; 224 vs 225 for the top bit.
      add(0, 8'h20, 7, 8'h08, 8'h01);
      add(0, 8'h20, 1, 8'h20, 8'h01);
      add(0, 8'h21, 7, 8'h20, 8'h01);
      add(0, 8'h21, 1, 8'h21, 8'h03);
      add(0, 8'hE0, 7, 8'h21, 8'h03);
      add(0, 8'hE0, 1, 8'hE0, 8'h7F);
      add(0, 8'hE1, 7, 8'hE0, 8'h7F);
      add(0, 8'hE1, 1, 8'hE1, 8'hFF);

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].d);
         check("vec", i, vecs[i].exp_out, vecs[i].exp_led);
      end

      // Reset on the last-sample edge wins over the window update.
      for (int i = 0; i < 7; i++) begin
         apply(1'b0, 8'h40);
         check("rst_last_pre", i, 8'hE1, 8'hFF);
      end
      apply(1'b1, 8'h40);
      check("rst_last_edge", 0, 8'h00, 8'h00);
      for (int i = 0; i < 7; i++) begin
         apply(1'b0, 8'h18);
         check("rst_last_post", i, 8'h00, 8'h00);
      end
      apply(1'b0, 8'h18);
      check("rst_last_done", 0, 8'h18, 8'h01);

      // Held output between windows, then one more boundary window.
      for (int i = 0; i < 7; i++) begin
         apply(1'b0, 8'h80);
         check("hold", i, 8'h18, 8'h01);
      end
      apply(1'b0, 8'h81);
      check("half_scale", 0, 8'h80, 8'h0F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
